br_credit_push_fifo_ctrl: RTL and testbench

BR_CREDIT_PUSH_FIFO_CTRL -- requirements
Module: br_credit_push_fifo_ctrl

---
 rtl/br_math_pkg.sv | 15 +
 rtl/br_credit_push_fifo_ctrl_chk.sv | 20 ++
 rtl/br_credit_receiver.sv | 103 ++++++++++
 rtl/br_credit_push_fifo_ctrl.sv | 152 +++++++++++++++
 tb/tb_br_credit_push_fifo_ctrl.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/br_math_pkg.sv
// Shared math helpers for width derivation in the br_* blocks.
package br_math;

    // Width needed to address 'value' items, never less than one bit.
    function automatic int clamped_clog2(input int value);
        int result;
        if (value <= 32'sd1) begin
            result = 32'sd1;
        end else begin
            result = $clog2(value);
        end
        return result;
    endfunction

endpackage

// File: rtl/br_credit_push_fifo_ctrl_chk.sv
// Error checks for the push controller: overflow, slot range, address range.
module br_credit_push_fifo_ctrl_chk #(
    parameter int Depth      = 2,
    parameter int RamDepth   = 2,
    parameter int CountWidth = 2,
    parameter int AddrWidth  = 1
) (
    input logic                  clk,
    input logic                  rst,
    input logic                  valid,
    input logic                  full,
    input logic [CountWidth-1:0] slots,
    input logic [AddrWidth-1:0]  ram_wr_addr
);

    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(valid && full));
    a_slots_in_range:    assert property (@(posedge clk) disable iff (rst) 32'(slots) <= Depth);
    a_addr_in_range:     assert property (@(posedge clk) disable iff (rst) 32'(ram_wr_addr) < RamDepth);

endmodule

// File: rtl/br_credit_receiver.sv
// Credit receiver: tracks credits held for the sender, returns them when
// allowed, and optionally registers the credit and the incoming push.
module br_credit_receiver
    import br_math::*;
#(
    parameter int Width               = 1,
    parameter int MaxCredit           = 2,
    parameter int RegisterPushOutputs = 0,
    parameter int CreditWidth         = $clog2(MaxCredit + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_sender_in_reset,
    output logic                   push_receiver_in_reset,
    input  logic                   push_credit_stall,
    output logic                   push_credit,
    input  logic                   push_valid,
    input  logic [Width-1:0]       push_data,
    output logic                   valid,
    output logic [Width-1:0]       data,
    input  logic [CreditWidth-1:0] credit_initial,
    input  logic [CreditWidth-1:0] credit_withhold,
    output logic [CreditWidth-1:0] credit_count,
    output logic [CreditWidth-1:0] credit_available,
    input  logic                   pop_credit
);

    logic [CreditWidth-1:0] count_r;
    logic [CreditWidth-1:0] count_next_s;
    logic [CreditWidth-1:0] available_s;
    logic                   grant_s;

    // The sender reset never reaches this output combinationally.
    assign push_receiver_in_reset = rst;

    // Releasable credits: held minus withheld, floored at zero.
    always_comb begin
        available_s = '0;
        if (count_r > credit_withhold) begin
            available_s = count_r - credit_withhold;
        end else begin
            available_s = '0;
        end
    end

    assign grant_s = (available_s != '0) && !push_credit_stall && !rst && !push_sender_in_reset;

    // Next credit count: a grant and a freed entry in the same cycle cancel.
    always_comb begin
        count_next_s = count_r;
        case ({grant_s, pop_credit})
            2'b10:   count_next_s = count_r - CreditWidth'(1);
            2'b01:   count_next_s = count_r + CreditWidth'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Credit counter; reloads the initial credit while either side is in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= credit_initial;
        end else if (push_sender_in_reset) begin
            count_r <= credit_initial;
        end else begin
            count_r <= count_next_s;
        end
    end

    assign credit_count     = count_r;
    assign credit_available = available_s;

    if (RegisterPushOutputs != 0) begin : g_reg
        logic             credit_r;
        logic             valid_r;
        logic [Width-1:0] data_r;

        // One-cycle retiming of the credit return and the incoming push.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                credit_r <= 1'b0;
                valid_r  <= 1'b0;
                data_r   <= '0;
            end else if (push_sender_in_reset) begin
                credit_r <= 1'b0;
                valid_r  <= 1'b0;
                data_r   <= '0;
            end else begin
                credit_r <= grant_s;
                valid_r  <= push_valid;
                data_r   <= push_data;
            end
        end

        assign push_credit = credit_r;
        assign valid       = valid_r;
        assign data        = data_r;
    end else begin : g_comb
        assign push_credit = grant_s;
        assign valid       = push_valid;
        assign data        = push_data;
    end

endmodule

// File: rtl/br_credit_push_fifo_ctrl.sv
// Push-side controller of a credit-based FIFO: credit return, free-slot
// tracking, full flag, RAM write address generation and optional bypass.
module br_credit_push_fifo_ctrl
    import br_math::*;
#(
    parameter int Depth               = 2,
    parameter int Width               = 1,
    parameter int EnableBypass        = 0,
    parameter int MaxCredit           = Depth,
    parameter int RegisterPushOutputs = 0,
    parameter int RamDepth            = Depth,
    localparam int AddrWidth          = clamped_clog2(RamDepth),
    localparam int CountWidth         = $clog2(Depth + 1),
    localparam int CreditWidth        = $clog2(MaxCredit + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_sender_in_reset,
    output logic                   push_receiver_in_reset,
    input  logic                   push_credit_stall,
    output logic                   push_credit,
    input  logic                   push_valid,
    input  logic [Width-1:0]       push_data,
    output logic                   full,
    output logic                   full_next,
    output logic [CountWidth-1:0]  slots,
    output logic [CountWidth-1:0]  slots_next,
    input  logic [CreditWidth-1:0] credit_initial_push,
    input  logic [CreditWidth-1:0] credit_withhold_push,
    output logic [CreditWidth-1:0] credit_count_push,
    output logic [CreditWidth-1:0] credit_available_push,
    input  logic                   bypass_ready,
    output logic                   bypass_valid_unstable,
    output logic [Width-1:0]       bypass_data_unstable,
    output logic                   ram_wr_valid,
    output logic [AddrWidth-1:0]   ram_wr_addr,
    output logic [Width-1:0]       ram_wr_data,
    output logic                   push_beat,
    input  logic                   pop_beat
);

    logic                  valid_s;
    logic [Width-1:0]      data_s;
    logic [CountWidth-1:0] slots_r;
    logic [CountWidth-1:0] slots_next_s;
    logic                  full_r;
    logic [AddrWidth-1:0]  addr_r;
    logic [AddrWidth-1:0]  addr_next_s;

    br_credit_receiver #(
        .Width              (Width),
        .MaxCredit          (MaxCredit),
        .RegisterPushOutputs(RegisterPushOutputs),
        .CreditWidth        (CreditWidth)
    ) u_credit_receiver (
        .clk                   (clk),
        .rst                   (rst),
        .push_sender_in_reset  (push_sender_in_reset),
        .push_receiver_in_reset(push_receiver_in_reset),
        .push_credit_stall     (push_credit_stall),
        .push_credit           (push_credit),
        .push_valid            (push_valid),
        .push_data             (push_data),
        .valid                 (valid_s),
        .data                  (data_s),
        .credit_initial        (credit_initial_push),
        .credit_withhold       (credit_withhold_push),
        .credit_count          (credit_count_push),
        .credit_available      (credit_available_push),
        .pop_credit            (pop_beat)
    );

    // Credit flow control guarantees space, so every valid is accepted.
    assign push_beat   = valid_s;
    assign ram_wr_data = data_s;

    if (EnableBypass != 0) begin : g_bypass
        assign bypass_valid_unstable = valid_s;
        assign bypass_data_unstable  = data_s;
        assign ram_wr_valid          = valid_s && !bypass_ready;
    end else begin : g_no_bypass
        assign bypass_valid_unstable = 1'b0;
        assign bypass_data_unstable  = '0;
        assign ram_wr_valid          = valid_s;
    end

    // Free-slot count after this cycle's push and pop.
    always_comb begin
        slots_next_s = slots_r;
        case ({push_beat, pop_beat})
            2'b10:   slots_next_s = slots_r - CountWidth'(1);
            2'b01:   slots_next_s = slots_r + CountWidth'(1);
            default: slots_next_s = slots_r;
        endcase
    end

    // Write pointer advances on every RAM write and wraps at the RAM size.
    always_comb begin
        addr_next_s = addr_r;
        if (ram_wr_valid) begin
            if (addr_r == AddrWidth'(RamDepth - 1)) begin
                addr_next_s = '0;
            end else begin
                addr_next_s = addr_r + AddrWidth'(1);
            end
        end else begin
            addr_next_s = addr_r;
        end
    end

    // Slot counter, full flag and write pointer state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slots_r <= CountWidth'(Depth);
            full_r  <= 1'b0;
            addr_r  <= '0;
        end else if (push_sender_in_reset) begin
            slots_r <= CountWidth'(Depth);
            full_r  <= 1'b0;
            addr_r  <= '0;
        end else begin
            slots_r <= slots_next_s;
            addr_r  <= addr_next_s;
            if (push_beat || pop_beat) begin
                full_r <= full_next;
            end else begin
                full_r <= full_r;
            end
        end
    end

    assign slots       = slots_r;
    assign slots_next  = slots_next_s;
    assign full_next   = (slots_next_s == '0);
    assign full        = full_r;
    assign ram_wr_addr = addr_r;

    br_credit_push_fifo_ctrl_chk #(
        .Depth     (Depth),
        .RamDepth  (RamDepth),
        .CountWidth(CountWidth),
        .AddrWidth (AddrWidth)
    ) u_chk (
        .clk        (clk),
        .rst        (rst),
        .valid      (valid_s),
        .full       (full_r),
        .slots      (slots_r),
        .ram_wr_addr(addr_r)
    );

endmodule

// File: tb/tb_br_credit_push_fifo_ctrl.sv
// Bench for br_credit_push_fifo_ctrl: directed stimulus, scoreboard queues
// for RAM writes and bypass beats, plus direct state checks.
module tb_br_credit_push_fifo_ctrl;

    localparam int Depth       = 4;
    localparam int Width       = 8;
    localparam int MaxCredit   = 4;
    localparam int CountWidth  = 3;
    localparam int CreditWidth = 3;
    localparam int AddrWidth   = 2;

    logic                   clk;
    logic                   rst;
    logic                   push_sender_in_reset;
    logic                   push_receiver_in_reset;
    logic                   push_credit_stall;
    logic                   push_credit;
    logic                   push_valid;
    logic [Width-1:0]       push_data;
    logic                   full;
    logic                   full_next;
    logic [CountWidth-1:0]  slots;
    logic [CountWidth-1:0]  slots_next;
    logic [CreditWidth-1:0] credit_initial_push;
    logic [CreditWidth-1:0] credit_withhold_push;
    logic [CreditWidth-1:0] credit_count_push;
    logic [CreditWidth-1:0] credit_available_push;
    logic                   bypass_ready;
    logic                   bypass_valid_unstable;
    logic [Width-1:0]       bypass_data_unstable;
    logic                   ram_wr_valid;
    logic [AddrWidth-1:0]   ram_wr_addr;
    logic [Width-1:0]       ram_wr_data;
    logic                   push_beat;
    logic                   pop_beat;

    br_credit_push_fifo_ctrl #(
        .Depth              (Depth),
        .Width              (Width),
        .EnableBypass       (1),
        .MaxCredit          (MaxCredit),
        .RegisterPushOutputs(0),
        .RamDepth           (Depth)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .push_sender_in_reset  (push_sender_in_reset),
        .push_receiver_in_reset(push_receiver_in_reset),
        .push_credit_stall     (push_credit_stall),
        .push_credit           (push_credit),
        .push_valid            (push_valid),
        .push_data             (push_data),
        .full                  (full),
        .full_next             (full_next),
        .slots                 (slots),
        .slots_next            (slots_next),
        .credit_initial_push   (credit_initial_push),
        .credit_withhold_push  (credit_withhold_push),
        .credit_count_push     (credit_count_push),
        .credit_available_push (credit_available_push),
        .bypass_ready          (bypass_ready),
        .bypass_valid_unstable (bypass_valid_unstable),
        .bypass_data_unstable  (bypass_data_unstable),
        .ram_wr_valid          (ram_wr_valid),
        .ram_wr_addr           (ram_wr_addr),
        .ram_wr_data           (ram_wr_data),
        .push_beat             (push_beat),
        .pop_beat              (pop_beat)
    );

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic [Width-1:0]     data;
    } wr_t;

    wr_t              wr_q[$];
    logic [Width-1:0] byp_q[$];
    int               tests;
    int               fails;
    int               credit_pulses;
    int               pulses_before;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the expected write/bypass beat whenever the DUT presents one.
    always @(negedge clk) begin : monitor
        wr_t              e;
        logic [Width-1:0] b;
        if (!rst) begin
            if (push_credit) credit_pulses++;
            if (ram_wr_valid) begin
                if (wr_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: addr %0d data %0h, none expected", ram_wr_addr, ram_wr_data);
                end else begin
                    e = wr_q.pop_front();
                    check("wr_addr", int'(ram_wr_addr), int'(e.addr));
                    check("wr_data", int'(ram_wr_data), int'(e.data));
                end
            end
            if (bypass_valid_unstable && bypass_ready) begin
                if (byp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_bypass: data %0h, none expected", bypass_data_unstable);
                end else begin
                    b = byp_q.pop_front();
                    check("bypass_data", int'(bypass_data_unstable), int'(b));
                end
            end
        end
    end

    initial begin
        tests = 0;
        fails = 0;
        credit_pulses = 0;
        rst = 1'b1;
        push_sender_in_reset = 1'b0;
        push_credit_stall = 1'b1;
        push_valid = 1'b0;
        push_data = 8'h00;
        credit_initial_push = 3'd4;
        credit_withhold_push = 3'd0;
        bypass_ready = 1'b0;
        pop_beat = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_receiver_in_reset", int'(push_receiver_in_reset), 1);
        check("rst_push_credit", int'(push_credit), 0);
        check("rst_slots", int'(slots), 4);
        check("rst_full", int'(full), 0);
        check("rst_addr", int'(ram_wr_addr), 0);
        check("rst_credit_count", int'(credit_count_push), 4);
        check("rst_credit_available", int'(credit_available_push), 4);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("receiver_in_reset_low", int'(push_receiver_in_reset), 0);
        step();

        // Four initial credits flow out over four cycles
        push_credit_stall = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("credit_count_drain", int'(credit_count_push), (i < 4) ? 4 - i : 0);
            check("credit_pulse", int'(push_credit), (i < 4) ? 1 : 0);
            step();
        end
        check("credit_pulses_initial", credit_pulses, 4);

        // Four pushes fill the FIFO
        for (int i = 0; i < 4; i++) begin
            push_valid = 1'b1;
            push_data = 8'h10 + 8'(i);
            wr_q.push_back({2'(i), 8'h10 + 8'(i)});
            @(negedge clk);
            check("fill_slots", int'(slots), 4 - i);
            check("fill_slots_next", int'(slots_next), 3 - i);
            check("fill_full_next", int'(full_next), (i == 3) ? 1 : 0);
            check("fill_full", int'(full), 0);
            step();
        end
        push_valid = 1'b0;
        @(negedge clk);
        check("full_after_fill", int'(full), 1);
        check("slots_after_fill", int'(slots), 0);
        check("addr_wrapped", int'(ram_wr_addr), 0);
        step();

        // Two pops bring slots to 2, credits held back by stall
        push_credit_stall = 1'b1;
        pop_beat = 1'b1;
        step();
        @(negedge clk);
        check("full_cleared_by_pop", int'(full), 0);
        step();
        pop_beat = 1'b0;

        // Simultaneous push and pop at slots=2
        push_valid = 1'b1;
        pop_beat = 1'b1;
        push_data = 8'h20;
        wr_q.push_back({2'd0, 8'h20});
        @(negedge clk);
        check("pp_slots", int'(slots), 2);
        check("pp_slots_next", int'(slots_next), 2);
        check("pp_full_next", int'(full_next), 0);
        step();
        push_valid = 1'b0;
        pop_beat = 1'b0;
        @(negedge clk);
        check("pp_slots_after", int'(slots), 2);
        check("pp_full_after", int'(full), 0);
        check("credit_after_3_pops", int'(credit_count_push), 3);

        // Withhold 3 of 4 credits: exactly one is released
        step();
        pop_beat = 1'b1;
        step();
        pop_beat = 1'b0;
        credit_withhold_push = 3'd3;
        @(negedge clk);
        check("withhold_count", int'(credit_count_push), 4);
        check("withhold_available", int'(credit_available_push), 1);
        step();
        pulses_before = credit_pulses;
        push_credit_stall = 1'b0;
        repeat (4) step();
        @(negedge clk);
        check("withhold_one_credit", credit_pulses - pulses_before, 1);
        check("withhold_count_after", int'(credit_count_push), 3);
        check("withhold_available_after", int'(credit_available_push), 0);
        step();

        // Sender reset mid-traffic
        push_credit_stall = 1'b1;
        credit_withhold_push = 3'd0;
        push_valid = 1'b1;
        push_data = 8'h30;
        wr_q.push_back({2'd1, 8'h30});
        step();
        push_valid = 1'b0;
        push_sender_in_reset = 1'b1;
        push_credit_stall = 1'b0;
        @(negedge clk);
        check("sreset_no_credit", int'(push_credit), 0);
        check("sreset_receiver_not_in_reset", int'(push_receiver_in_reset), 0);
        step();
        push_sender_in_reset = 1'b0;
        push_credit_stall = 1'b1;
        @(negedge clk);
        check("sreset_slots", int'(slots), 4);
        check("sreset_full", int'(full), 0);
        check("sreset_addr", int'(ram_wr_addr), 0);
        check("sreset_credit_count", int'(credit_count_push), 4);
        step();

        // Bypass accepted: no RAM write, address holds
        bypass_ready = 1'b1;
        push_valid = 1'b1;
        push_data = 8'hA5;
        byp_q.push_back(8'hA5);
        @(negedge clk);
        check("bypass_valid", int'(bypass_valid_unstable), 1);
        check("bypass_ram_wr_valid", int'(ram_wr_valid), 0);
        check("bypass_push_beat", int'(push_beat), 1);
        step();
        check("bypass_addr_unchanged", int'(ram_wr_addr), 0);
        bypass_ready = 1'b0;
        push_data = 8'h5A;
        wr_q.push_back({2'd0, 8'h5A});
        @(negedge clk);
        check("nobypass_ram_wr_valid", int'(ram_wr_valid), 1);
        check("nobypass_bypass_valid", int'(bypass_valid_unstable), 1);
        step();
        push_valid = 1'b0;
        @(negedge clk);
        check("final_slots", int'(slots), 2);
        check("final_addr", int'(ram_wr_addr), 1);

        repeat (2) step();
        check("wr_queue_drained", wr_q.size(), 0);
        check("bypass_queue_drained", byp_q.size(), 0);
        check("credit_pulses_total", credit_pulses, 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
